multicycle_datapath: RTL

//  Parametrised multi-cycle datapath for the 16-bit RISC core; next generation of the single-cycle datapath.

---
 rtl/multicycle_datapath.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_datapath
// Description : 16-bit RISC multi-cycle datapath (FETCH/DECODE/EXEC/MEM/WB)
//               with PC, IR, MDR, 8-entry register file and req/ready memories.
//               Optional macro DP_PERF_CNT_EN adds cycle/retired counters.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_datapath #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [1:0]        alu_op,
    output logic [3:0]        opcode,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              instr_done
`ifdef DP_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retired_cnt
`endif
);

    localparam int NREGS = 8;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    typedef struct packed {
        logic       jump;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [2:0]        rs, rt, rd;
    logic [5:0]        imm;
    logic [DATA_W-1:0] imm_ext, op2, alu_res;
    logic [PC_W-1:0]   imm_pc, pc2, jump_tgt, br_tgt, pc_next;
    logic              zero, done;

    assign rs      = ir_q[11:9];
    assign rt      = ir_q[8:6];
    assign rd      = ir_q[5:3];
    assign imm     = ir_q[5:0];
    assign imm_ext = {{(DATA_W-6){imm[5]}}, imm};
    assign imm_pc  = {{(PC_W-6){imm[5]}}, imm};
    assign op2     = ctrl_q.alu_src ? imm_ext : b_q;

    always_comb begin
        alu_res = '0;
        case (ctrl_q.alu_op)
            2'b10: alu_res = a_q + op2;
            2'b01: alu_res = a_q - op2;
            default: begin
                case (ir_q[14:12])
                    3'b000:  alu_res = a_q + op2;
                    3'b001:  alu_res = a_q - op2;
                    3'b010:  alu_res = ~a_q;
                    3'b011:  alu_res = a_q << op2;
                    3'b100:  alu_res = a_q >> op2;
                    3'b101:  alu_res = a_q & op2;
                    3'b110:  alu_res = a_q | op2;
                    default: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(op2))};
                endcase
            end
        endcase
    end

    assign zero = (alu_res == '0);

    // Jump keeps the PC bits above the 13-bit page from pc2.
    always_comb begin
        pc2            = pc_q + PC_W'(2);
        br_tgt         = pc2 + (imm_pc << 1);
        jump_tgt       = pc2;
        jump_tgt[12:0] = {ir_q[11:0], 1'b0};
        if (ctrl_q.jump)
            pc_next = jump_tgt;
        else if (ctrl_q.bne && !zero)
            pc_next = br_tgt;
        else if (ctrl_q.beq && zero)
            pc_next = br_tgt;
        else
            pc_next = pc2;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        ctrl_d   = ctrl_q;
        regs_d   = regs_q;
        done     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                ctrl_d  = '{jump, beq, bne, mem_read, mem_write, alu_src,
                            reg_dst, mem_to_reg, reg_write, alu_op};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                aluout_d = alu_res;
                pc_d     = pc_next;
                if (ctrl_q.jump || ctrl_q.beq || ctrl_q.bne) begin
                    state_d = ST_FETCH;
                    done    = 1'b1;
                end else if (ctrl_q.mem_read || ctrl_q.mem_write) begin
                    state_d = ST_MEM;
                end else if (ctrl_q.reg_write) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                    done    = 1'b1;
                end
            end
            ST_MEM: begin
                // A combined read+write strobe behaves as a store.
                if (dmem_ready) begin
                    if (ctrl_q.mem_write) begin
                        state_d = ST_FETCH;
                        done    = 1'b1;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                if (ctrl_q.reg_write)
                    regs_d[ctrl_q.reg_dst ? rd : rt] = ctrl_q.mem_to_reg ? mdr_q : aluout_q;
                done    = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            ctrl_q   <= '0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            ctrl_q   <= ctrl_d;
            regs_q   <= regs_d;
        end
    end

    // Fetch request is gated by rst_n so it drops the instant reset asserts.
    assign imem_req   = rst_n && (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign opcode     = ir_q[15:12];
    assign dmem_req   = (state_q == ST_MEM);
    assign dmem_we    = (state_q == ST_MEM) && ctrl_q.mem_write;
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = b_q;
    assign instr_done = done;

`ifdef DP_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        retired_cnt_d = retired_cnt_q + {31'd0, done};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule
`default_nettype wire
